// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control codes, MIPS funct codes and sequencer state encoding
package alu_pkg;
   localparam logic [7:0] ALU_NOP = 8'h00;
   localparam logic [7:0] ALU_ADD = 8'h01;
   localparam logic [7:0] ALU_SUB = 8'h02;
   localparam logic [7:0] ALU_MUL = 8'h03;
   localparam logic [7:0] ALU_DIV = 8'h04;
   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_MUL = 6'h18;
   localparam logic [5:0] F_DIV = 6'h1A;
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;
endpackage

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: maps a MIPS funct code to the ALU control code and flags unsupported functs
module alu_funct_decode
   import alu_pkg::*;
(
   input  logic [5:0] i_funct,
   output logic [7:0] o_control,
   output logic       o_illegal
);
   // NOP doubles as the marker for any funct the ALU does not implement
   always_comb begin
      o_control = (i_funct == F_ADD) ? ALU_ADD :
                  (i_funct == F_SUB) ? ALU_SUB :
                  (i_funct == F_MUL) ? ALU_MUL :
                  (i_funct == F_DIV) ? ALU_DIV : ALU_NOP;
      o_illegal = (o_control == ALU_NOP);
   end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts ALU requests, holds them on the ALU for EXEC_CYCLES cycles and returns the captured result
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int EXEC_CYCLES = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [5:0]  i_req_funct,
   input  logic [31:0] i_req_a,
   input  logic [31:0] i_req_b,
   output logic [31:0] o_alu_input1,
   output logic [31:0] o_alu_input2,
   output logic [7:0]  o_alu_control,
   input  logic [31:0] i_alu_result,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_result,
   output logic        o_rsp_divzero,
   output logic        o_rsp_illegal
);
   localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(EXEC_CYCLES - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_alu_a;
   logic [31:0]   r_alu_b;
   logic [7:0]    r_alu_ctrl;
   logic          r_illegal_pend;
   logic          r_divzero_pend;
   logic          r_req_ready;
   logic          r_rsp_valid;
   logic [31:0]   r_rsp_result;
   logic          r_rsp_divzero;
   logic          r_rsp_illegal;
   logic [7:0]    w_control;
   logic          w_illegal;
   logic          w_divzero;

   alu_funct_decode u_decode (
      .i_funct   (i_req_funct),
      .o_control (w_control),
      .o_illegal (w_illegal)
   );

   assign w_divzero     = (w_control == ALU_DIV) && (i_req_b == 32'd0);
   assign o_req_ready   = r_req_ready;
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_result  = r_rsp_result;
   assign o_rsp_divzero = r_rsp_divzero;
   assign o_rsp_illegal = r_rsp_illegal;
   assign o_alu_input1  = r_alu_a;
   assign o_alu_input2  = r_alu_b;
   assign o_alu_control = r_alu_ctrl;

   // IDLE -> EXEC -> RESP sequencer; ALU drive is registered so it only moves on clock edges
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_alu_a        <= '0;
         r_alu_b        <= '0;
         r_alu_ctrl     <= ALU_NOP;
         r_illegal_pend <= 1'b0;
         r_divzero_pend <= 1'b0;
         r_req_ready    <= 1'b1;
         r_rsp_valid    <= 1'b0;
         r_rsp_result   <= '0;
         r_rsp_divzero  <= 1'b0;
         r_rsp_illegal  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (i_req_valid) begin
               r_state        <= ST_EXEC;
               r_req_ready    <= 1'b0;
               r_cnt          <= '0;
               r_alu_a        <= i_req_a;
               r_alu_b        <= i_req_b;
               r_alu_ctrl     <= w_divzero ? ALU_NOP : w_control;
               r_illegal_pend <= w_illegal;
               r_divzero_pend <= w_divzero;
               r_rsp_result   <= '0;
               r_rsp_divzero  <= 1'b0;
               r_rsp_illegal  <= 1'b0;
            end
            ST_EXEC: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == LAST) begin
                  r_state       <= ST_RESP;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_result  <= r_illegal_pend ? 32'd0 : r_divzero_pend ? 32'hFFFF_FFFF : i_alu_result;
                  r_rsp_illegal <= r_illegal_pend;
                  r_rsp_divzero <= r_divzero_pend;
                  r_alu_a       <= '0;
                  r_alu_b       <= '0;
                  r_alu_ctrl    <= ALU_NOP;
               end
            end
            ST_RESP: if (i_rsp_ready) begin
               r_state     <= ST_IDLE;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized scoreboard bench for alu_sequencer plus directed multicycle/reset checks
module tb_alu_sequencer;
   typedef struct {
      logic [31:0] res;
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  ctl;
      logic        dz;
      logic        il;
      int          acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc++;

   int total = 0;
   int bad = 0;
   int bp = 0;
   exp_t q[$];

   logic        r1 = 1'b1, v1 = 1'b0, rr1 = 1'b1;
   logic [5:0]  f1 = '0;
   logic [31:0] a1 = '0, b1 = '0;
   logic        rdy1, rv1, rdz1, ril1;
   logic [31:0] in1_1, in2_1, res1, rres1;
   logic [7:0]  ctl1;

   logic        r4 = 1'b1, v4 = 1'b0, rr4 = 1'b1;
   logic [5:0]  f4 = '0;
   logic [31:0] a4 = '0, b4 = '0;
   logic        rdy4, rv4, rdz4, ril4;
   logic [31:0] in1_4, in2_4, res4, rres4;
   logic [7:0]  ctl4;

   function automatic logic [31:0] alu_model(input logic [7:0] c, input logic [31:0] x, input logic [31:0] y);
      case (c)
         8'h01:   return x + y;
         8'h02:   return x - y;
         8'h03:   return x * y;
         8'h04:   return (y == 0) ? 32'd0 : x / y;
         default: return 32'd0;
      endcase
   endfunction

   assign res1 = alu_model(ctl1, in1_1, in2_1);
   assign res4 = alu_model(ctl4, in1_4, in2_4);

   alu_sequencer #(.EXEC_CYCLES(1)) dut1 (
      .i_clk(clk), .i_reset(r1), .i_req_valid(v1), .o_req_ready(rdy1), .i_req_funct(f1),
      .i_req_a(a1), .i_req_b(b1), .o_alu_input1(in1_1), .o_alu_input2(in2_1), .o_alu_control(ctl1),
      .i_alu_result(res1), .o_rsp_valid(rv1), .i_rsp_ready(rr1), .o_rsp_result(rres1),
      .o_rsp_divzero(rdz1), .o_rsp_illegal(ril1));

   alu_sequencer #(.EXEC_CYCLES(4)) dut4 (
      .i_clk(clk), .i_reset(r4), .i_req_valid(v4), .o_req_ready(rdy4), .i_req_funct(f4),
      .i_req_a(a4), .i_req_b(b4), .o_alu_input1(in1_4), .o_alu_input2(in2_4), .o_alu_control(ctl4),
      .i_alu_result(res4), .o_rsp_valid(rv4), .i_rsp_ready(rr4), .o_rsp_result(rres4),
      .o_rsp_divzero(rdz4), .o_rsp_illegal(ril4));

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output exp_t e);
      e.a = a; e.b = b; e.dz = 1'b0; e.il = 1'b0; e.acc = 0;
      case (f)
         6'h20: begin e.res = a + b; e.ctl = 8'h01; end
         6'h22: begin e.res = a - b; e.ctl = 8'h02; end
         6'h18: begin e.res = a * b; e.ctl = 8'h03; end
         6'h1A: if (b == 0) begin e.res = 32'hFFFF_FFFF; e.dz = 1'b1; e.ctl = 8'h00; end
                else begin e.res = a / b; e.ctl = 8'h04; end
         default: begin e.res = 32'd0; e.il = 1'b1; e.ctl = 8'h00; end
      endcase
   endtask

   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int n = 0;
      @(negedge clk);
      v1 = 1'b1; f1 = f; a1 = a; b1 = b;
      while (!rdy1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("accept", {31'd0, rdy1}, 32'd1);
      if (rdy1) begin
         model(f, a, b, e);
         e.acc = cyc + 1;
         q.push_back(e);
      end
      @(negedge clk);
      v1 = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("drain", q.size(), 0);
   endtask

   always begin
      @(posedge clk);
      #1 rr1 = (bp == 0) ? 1'b1 : (bp == 1) ? 1'($urandom % 2) : 1'b0;
   end

   bit seen = 1'b0;
   always @(negedge clk) begin
      if (!r1) begin
         if (rv1) begin
            chk("ready_low_in_resp", {31'd0, rdy1}, 32'd0);
            if (q.size() == 0) chk("spurious_rsp", {31'd0, rv1}, 32'd0);
            else begin
               if (!seen) chk("latency", 32'(cyc - q[0].acc), 32'd1);
               seen = 1'b1;
               chk("rsp_result", rres1, q[0].res);
               chk("rsp_divzero", {31'd0, rdz1}, {31'd0, q[0].dz});
               chk("rsp_illegal", {31'd0, ril1}, {31'd0, q[0].il});
               if (rr1) begin
                  void'(q.pop_front());
                  seen = 1'b0;
               end
            end
         end else if (!rdy1 && q.size() > 0) begin
            chk("exec_ctl", {24'd0, ctl1}, {24'd0, q[0].ctl});
            chk("exec_in1", in1_1, q[0].a);
            chk("exec_in2", in2_1, q[0].b);
         end else if (rdy1) begin
            chk("idle_ctl", {24'd0, ctl1}, 32'd0);
            chk("idle_in1", in1_1 | in2_1, 32'd0);
         end
      end
   end

   task automatic chk_reset4(input string n);
      chk({n, "_ready"}, {31'd0, rdy4}, 32'd1);
      chk({n, "_valid"}, {31'd0, rv4}, 32'd0);
      chk({n, "_result"}, rres4, 32'd0);
      chk({n, "_flags"}, {30'd0, rdz4, ril4}, 32'd0);
      chk({n, "_alu"}, in1_4 | in2_4 | {24'd0, ctl4}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] fs [5];
      fs[0] = 6'h20; fs[1] = 6'h22; fs[2] = 6'h18; fs[3] = 6'h1A; fs[4] = 6'h00;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'd0, rdy1}, 32'd1);
      chk("rst_valid", {31'd0, rv1}, 32'd0);
      chk("rst_result", rres1, 32'd0);
      chk("rst_flags", {30'd0, rdz1, ril1}, 32'd0);
      chk("rst_alu", in1_1 | in2_1 | {24'd0, ctl1}, 32'd0);
      chk_reset4("rst4");
      r1 = 1'b0;
      r4 = 1'b0;
      issue(6'h20, 32'd5, 32'd7);
      issue(6'h22, 32'd0, 32'd1);
      issue(6'h18, 32'h10000, 32'h10000);
      issue(6'h1A, 32'd9, 32'd0);
      issue(6'h1A, 32'd9, 32'd2);
      drain();
      bp = 2;
      issue(6'h3F, 32'd1, 32'd2);
      fork
         begin
            repeat (7) @(negedge clk);
            bp = 0;
         end
      join_none
      issue(6'h20, 32'd1, 32'd1);
      drain();
      bp = 1;
      repeat (40) begin
         logic [5:0] f;
         logic [31:0] b;
         f = ($urandom % 8 == 0) ? 6'($urandom) : fs[$urandom % 4];
         b = ($urandom % 4 == 0) ? 32'd0 : ($urandom % 2 == 0) ? 32'($urandom % 16) : $urandom;
         issue(f, $urandom, b);
         repeat ($urandom % 3) @(negedge clk);
      end
      drain();
      bp = 0;
      @(negedge clk);
      v4 = 1'b1; f4 = 6'h20; a4 = 32'd3; b4 = 32'd4;
      chk("m4_ready", {31'd0, rdy4}, 32'd1);
      @(negedge clk);
      v4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("m4_exec_ctl", {24'd0, ctl4}, 32'h01);
         chk("m4_exec_ops", {in1_4[15:0], in2_4[15:0]}, {16'd3, 16'd4});
         chk("m4_exec_novalid", {31'd0, rv4}, 32'd0);
         @(negedge clk);
      end
      chk("m4_valid", {31'd0, rv4}, 32'd1);
      chk("m4_result", rres4, 32'd7);
      chk("m4_flags", {30'd0, rdz4, ril4}, 32'd0);
      chk("m4_resp_ctl", {24'd0, ctl4}, 32'd0);
      @(negedge clk);
      chk("m4_back_idle", {30'd0, rdy4, rv4}, 32'b10);
      v4 = 1'b1; f4 = 6'h20; a4 = 32'd10; b4 = 32'd20;
      @(negedge clk);
      v4 = 1'b0;
      chk("m4b_exec_ctl", {24'd0, ctl4}, 32'h01);
      @(negedge clk);
      #2 r4 = 1'b1;
      #1 chk_reset4("mid_exec_rst");
      @(negedge clk);
      r4 = 1'b0;
      repeat (6) begin
         @(negedge clk);
         chk("post_rst_novalid", {30'd0, rdy4, rv4}, 32'b10);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
